// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the MEM-stage access sequencer.
package pipe_mem_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    IO_DONE  = 2'd3
  } state_t;

  // Load data returned to the pipeline when an IO access times out.
  localparam logic [31:0] IO_TIMEOUT_DATA = 32'h0;

  // Width of the IO address bus.
  localparam int IO_ADDR_W = 8;

  // Width of the shared wait counter.
  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter shared by RAM-latency and IO-timeout waits.
// It stops at zero rather than wrapping.
module mem_wait_counter
  import pipe_mem_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pipe_mem_ctrl.sv
// MEM-stage access sequencer: routes loads/stores to data RAM or IO,
// inserts wait states and supplies the load data latched by MEM/WB.
module pipe_mem_ctrl
  import pipe_mem_pkg::*;
#(
  parameter int RAM_LAT    = 1,
  parameter int IO_TIMEOUT = 15,
  parameter int IO_BIT     = 7
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 mwmem,
  input  logic                 mm2reg,
  input  logic [31:0]          malu,
  input  logic [31:0]          mb,
  input  logic [31:0]          ram_rdata,
  output logic                 ram_we,
  output logic                 io_req,
  output logic                 io_we,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [31:0]          io_wdata,
  input  logic                 io_ack,
  input  logic [31:0]          io_rdata,
  input  logic                 err_clr,
  output logic                 stall,
  output logic [31:0]          mmo,
  output logic                 bus_err
);

  // A zero-latency RAM load completes in IDLE without a wait state.
  localparam bit               RAM_HAS_WAIT = (RAM_LAT != 0);
  localparam logic [CNT_W-1:0] RAM_LOAD_VAL = CNT_W'((RAM_LAT > 0) ? (RAM_LAT - 1) : 0);
  localparam logic [CNT_W-1:0] IO_LOAD_VAL  = CNT_W'(IO_TIMEOUT);

  state_t state_r;
  state_t state_next_s;

  logic access_s;
  logic io_sel_s;
  logic is_store_s;
  logic is_load_s;
  logic io_start_s;
  logic io_timeout_s;
  logic io_finish_s;

  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic [CNT_W-1:0] cnt_value_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_s;

  logic        stall_s;
  logic        ram_we_s;
  logic [31:0] mmo_s;

  logic                 io_req_r;
  logic                 io_we_r;
  logic [IO_ADDR_W-1:0] io_addr_r;
  logic [31:0]          io_wdata_r;
  logic [31:0]          rdata_r;
  logic                 bus_err_r;

  // Only the IO select bit and the low address byte are decoded.
  logic unused_malu_s;
  assign unused_malu_s = ^malu;

  // A simultaneous store and load is treated as a store.
  assign access_s   = mwmem | mm2reg;
  assign io_sel_s   = malu[IO_BIT];
  assign is_store_s = mwmem;
  assign is_load_s  = mm2reg & ~mwmem;
  assign io_start_s = (state_r == IDLE) & access_s & io_sel_s;

  // The last IO_WAIT cycle is the one where the counter would reach zero;
  // an ack on that same cycle wins over the timeout.
  assign io_timeout_s = (state_r == IO_WAIT) & ~io_ack & (cnt_s <= 8'd1);
  assign io_finish_s  = (state_r == IO_WAIT) & (io_ack | io_timeout_s);

  mem_wait_counter u_wait_cnt (
    .clock  (clock),
    .resetn (resetn),
    .load   (cnt_load_s),
    .value  (cnt_value_s),
    .dec    (cnt_dec_s),
    .zero   (cnt_zero_s),
    .count  (cnt_s)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s && io_sel_s) begin
          state_next_s = IO_WAIT;
        end else if (is_load_s && RAM_HAS_WAIT) begin
          state_next_s = RAM_WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      RAM_WAIT: begin
        if (cnt_zero_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAM_WAIT;
        end
      end
      IO_WAIT: begin
        if (io_finish_s) begin
          state_next_s = IO_DONE;
        end else begin
          state_next_s = IO_WAIT;
        end
      end
      IO_DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Stall, RAM write strobe, counter control and load-data mux.
  always_comb begin
    stall_s     = 1'b0;
    ram_we_s    = 1'b0;
    mmo_s       = ram_rdata;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    cnt_value_s = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (access_s && io_sel_s) begin
          stall_s     = 1'b1;
          cnt_load_s  = 1'b1;
          cnt_value_s = IO_LOAD_VAL;
        end else if (is_store_s) begin
          ram_we_s = 1'b1;
        end else if (is_load_s && RAM_HAS_WAIT) begin
          stall_s     = 1'b1;
          cnt_load_s  = 1'b1;
          cnt_value_s = RAM_LOAD_VAL;
        end else begin
          stall_s = 1'b0;
        end
      end
      RAM_WAIT: begin
        stall_s   = ~cnt_zero_s;
        cnt_dec_s = ~cnt_zero_s;
      end
      IO_WAIT: begin
        stall_s   = 1'b1;
        cnt_dec_s = 1'b1;
        mmo_s     = rdata_r;
      end
      IO_DONE: begin
        mmo_s = rdata_r;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // IO request and its latched address, data and direction.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      io_req_r   <= 1'b0;
      io_we_r    <= 1'b0;
      io_addr_r  <= {IO_ADDR_W{1'b0}};
      io_wdata_r <= 32'h0;
    end else if (io_start_s) begin
      io_req_r   <= 1'b1;
      io_we_r    <= mwmem;
      io_addr_r  <= malu[IO_ADDR_W-1:0];
      io_wdata_r <= mb;
    end else if (io_finish_s) begin
      io_req_r <= 1'b0;
    end else begin
      io_req_r <= io_req_r;
    end
  end

  // IO read data captured on ack, forced to the timeout value on expiry.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= 32'h0;
    end else if ((state_r == IO_WAIT) && io_ack) begin
      rdata_r <= io_rdata;
    end else if (io_timeout_s) begin
      rdata_r <= IO_TIMEOUT_DATA;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= io_timeout_s | (bus_err_r & ~err_clr);
    end
  end

  assign stall    = stall_s & resetn;
  assign ram_we   = ram_we_s & resetn;
  assign mmo      = mmo_s;
  assign io_req   = io_req_r;
  assign io_we    = io_we_r;
  assign io_addr  = io_addr_r;
  assign io_wdata = io_wdata_r;
  assign bus_err  = bus_err_r;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Self-checking bench for pipe_mem_ctrl: directed scenarios followed by
// randomized accesses scored against a transaction-level model.
module tb_pipe_mem_ctrl;

  localparam int RAM_LAT    = 1;
  localparam int IO_TIMEOUT = 15;
  localparam int IO_BIT     = 7;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mwmem, mm2reg;
  logic [31:0] malu, mb, ram_rdata;
  logic        ram_we;
  logic        io_req, io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic        err_clr;
  logic        stall;
  logic [31:0] mmo;
  logic        bus_err;

  int   nvec = 0;
  int   nerr = 0;
  logic err_model = 1'b0;

  always #5 clock = ~clock;

  pipe_mem_ctrl #(.RAM_LAT(RAM_LAT), .IO_TIMEOUT(IO_TIMEOUT), .IO_BIT(IO_BIT)) dut (
    .clock(clock), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg),
    .malu(malu), .mb(mb), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata), .err_clr(err_clr),
    .stall(stall), .mmo(mmo), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MEM-stage access. kind: 0 load, 1 store, 2 store+load (acts as store).
  // ack_at: IO_WAIT cycle (1-based) in which io_ack pulses; out of range = none.
  // clr_at: stalled cycle in which err_clr pulses (0 = never).
  task automatic do_access(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_at, input int clr_at);
    bit          is_io, st, to, cleared;
    int          exp_n, n, we_cnt;
    logic [31:0] exp_mmo;
    is_io = addr[IO_BIT];
    st    = (kind != 0);
    if (!is_io) begin
      to      = 1'b0;
      exp_n   = st ? 0 : RAM_LAT;
      exp_mmo = rd;
    end else begin
      to      = (ack_at < 1) || (ack_at > IO_TIMEOUT);
      exp_n   = to ? IO_TIMEOUT + 1 : ack_at + 1;
      exp_mmo = to ? 32'h0 : rd;
    end
    cleared = (clr_at >= 1) && (clr_at <= exp_n - 1);

    @(negedge clock);
    mwmem = st; mm2reg = (kind != 1); malu = addr; mb = wd;
    ram_rdata = is_io ? ~rd : rd; io_ack = 1'b0; io_rdata = $urandom; err_clr = 1'b0;
    #1;
    n = 0; we_cnt = 0;
    while (stall === 1'b1 && n < 400) begin
      if (ram_we === 1'b1) we_cnt++;
      if (is_io && n == 0) check("io_req_idle", {31'b0, io_req}, 32'd0);
      if (is_io && n == 1) begin
        check("io_req", {31'b0, io_req}, 32'd1);
        check("io_addr", {24'b0, io_addr}, {24'b0, addr[7:0]});
        check("io_we", {31'b0, io_we}, {31'b0, st});
        check("io_wdata", io_wdata, wd);
      end
      n++;
      @(negedge clock);
      io_ack   = is_io && (n == ack_at);
      io_rdata = io_ack ? rd : $urandom;
      err_clr  = (clr_at != 0) && (n == clr_at);
      #1;
    end
    if (ram_we === 1'b1) we_cnt++;
    check("stall_cycles", n, exp_n);
    check("ram_we_count", we_cnt, (!is_io && st) ? 32'd1 : 32'd0);
    if (kind == 0 || is_io) check("mmo", mmo, exp_mmo);
    if (is_io) check("io_req_drop", {31'b0, io_req}, 32'd0);
    err_model = to | (err_model & ~cleared);
    check("bus_err", {31'b0, bus_err}, {31'b0, err_model});
  endtask

  task automatic clear_err();
    @(negedge clock);
    mwmem = 1'b0; mm2reg = 1'b0; io_ack = 1'b0; err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    #1;
    err_model = 1'b0;
    check("bus_err_clr", {31'b0, bus_err}, 32'd0);
  endtask

  initial begin
    int          we_cnt;
    int          kind, ackat;
    logic [31:0] a;

    // Reset with an IO load presented: nothing may start.
    resetn = 1'b0; mwmem = 1'b0; mm2reg = 1'b1; malu = 32'h84; mb = 32'h0;
    ram_rdata = 32'h0; io_ack = 1'b0; io_rdata = 32'h0; err_clr = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_io_req", {31'b0, io_req}, 32'd0);
    check("rst_io_we", {31'b0, io_we}, 32'd0);
    check("rst_io_addr", {24'b0, io_addr}, 32'd0);
    check("rst_io_wdata", io_wdata, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(negedge clock);
    mm2reg = 1'b0; resetn = 1'b1;

    // RAM load, RAM store, IO load with late ack.
    do_access(0, 32'h10, 32'h0, 32'h1234, 0, 0);
    do_access(1, 32'h20, 32'hAAAA, 32'h0, 0, 0);
    do_access(0, 32'h84, 32'h0, 32'hCAFE, 3, 0);

    // IO store timeout, then clear.
    do_access(1, 32'h84, 32'h55, 32'h0, 0, 0);
    clear_err();

    // Ack on the expiry cycle counts as success.
    do_access(0, 32'h90, 32'h0, 32'hBEEF, IO_TIMEOUT, 0);

    // Clear coincident with a new timeout: flag stays set.
    do_access(1, 32'h88, 32'h1, 32'h0, 0, IO_TIMEOUT);
    clear_err();

    // Store held in MEM while an IO load stalls: exactly one RAM write.
    @(negedge clock);
    mwmem = 1'b0; mm2reg = 1'b1; malu = 32'h84; io_ack = 1'b0; ram_rdata = 32'h0;
    #1;
    we_cnt = (ram_we === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      mwmem = 1'b1; mm2reg = 1'b0; malu = 32'h20; mb = 32'h77;
      io_ack = (k == 2); io_rdata = 32'h1357;
      #1;
      if (ram_we === 1'b1) we_cnt++;
      if (k == 3) check("held_mmo", mmo, 32'h1357);
      if (k == 4) check("held_stall", {31'b0, stall}, 32'd0);
    end
    @(negedge clock);
    mwmem = 1'b0; io_ack = 1'b0;
    #1;
    check("held_store_we", we_cnt, 32'd1);

    // Reset in the middle of IO_WAIT; a late ack must be ignored.
    @(negedge clock);
    mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h84; io_ack = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("mid_io_req", {31'b0, io_req}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_io_req", {31'b0, io_req}, 32'd0);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    @(negedge clock);
    mm2reg = 1'b0; resetn = 1'b1;
    @(negedge clock);
    io_ack = 1'b1; io_rdata = 32'hDEAD; ram_rdata = 32'h2468;
    @(negedge clock);
    io_ack = 1'b0;
    #1;
    err_model = 1'b0;
    check("late_ack_mmo", mmo, 32'h2468);
    check("late_ack_stall", {31'b0, stall}, 32'd0);
    check("late_ack_io_req", {31'b0, io_req}, 32'd0);
    check("late_ack_bus_err", {31'b0, bus_err}, 32'd0);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 2);
      a     = $urandom;
      a[IO_BIT] = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      ackat = $urandom_range(0, IO_TIMEOUT + 2);
      do_access(kind, a, $urandom, $urandom, ackat, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
